gcd_job_sequencer: RTL and testbench
====================================

Name: gcd_job_sequencer

Overview:
- Initiator/driver side of the top_gcd go/done interface.
- Accepts operand pairs on a valid/ready request port and launches each job on the GCD core with a one-cycle go pulse.
- Waits for the core's done, captures the result and presents it on a valid/ready response port.
- Sits between the system request source and top_gcd, so software/host logic never sequences go/done directly.

Parameters:
- WIDTH, 7, operand/result width; matches the core's data_sel_1/data_sel_2/out.
- CNT_W, 8, width of the completed-job counter.
- TIMEOUT_CYCLES, 255, WAIT-state watchdog limit. Used only when GCD_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request operand pair valid.
- req_ready  output  1  sequencer can accept a request.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- core_go  output  1  one-cycle launch pulse to the core.
- core_a  output  WIDTH  operand A to the core's data_sel_1.
- core_b  output  WIDTH  operand B to the core's data_sel_2.
- core_out  input  WIDTH  core result.
- core_done  input  1  core done; level, may stay high until the next go.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_gcd  output  WIDTH  GCD result.
- rsp_err  output  1  job aborted by timeout.
- busy  output  1  high in any state other than IDLE.
- job_count  output  CNT_W  completed-response count; wraps.

Behaviour:
- Reset: this block uses a synchronous, active-high reset, rst, on clock clk.
- Reset values: state=IDLE; core_go=0; core_a=core_b=0; rsp_valid=0; rsp_gcd=0; rsp_err=0; job_count=0; done_q=0; timeout counter=0.
- Reset asserted in any state aborts the job immediately.
  - No response is produced for the aborted job.
  - core_go is low in the cycle after reset.
- States: IDLE, LAUNCH, WAIT, RESP. req_ready = (state==IDLE); busy = (state!=IDLE).
- IDLE:
  - A request is accepted when req_valid && req_ready; latch req_a and req_b into operand registers.
  - If either operand is 0: go directly to RESP with rsp_gcd = a|b, which is 0 when both are 0, and rsp_err=0. The core is never launched.
  - Otherwise: go to LAUNCH.
- LAUNCH:
  - core_go=1 for exactly this one cycle.
  - core_a/core_b come from the operand registers and stay stable from LAUNCH until leaving WAIT.
  - Next state: WAIT.
- done_q:
  - done_q <= core_done every cycle.
  - A completion is core_done && !done_q, detected only in WAIT.
  - A stale-high done held over from the previous job is therefore never taken as completion; the core drops done on go.
- WAIT:
  - On completion: rsp_gcd <= core_out, rsp_err <= 0, go to RESP.
  - Non-edge high levels are ignored.
- RESP:
  - rsp_valid=1; rsp_gcd/rsp_err held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, job_count increments (modulo 2^CNT_W), next state IDLE.
  - req_ready is low throughout RESP, so a new request is accepted no earlier than the cycle after the handshake.
- Latency, nonzero operands: request accepted in cycle N; core_go high in N+1; WAIT from N+2. rsp_valid rises the cycle after the core's done edge is seen.
- Latency, zero operand: rsp_valid high in cycle N+1.
- Simultaneous events: core_done activity outside WAIT has no effect. No request is queued during a job; the requester sees req_ready=0 and holds.

Optional Feature:
- Macro: GCD_TIMEOUT_EN.
- When defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no completion: rsp_gcd <= 0, rsp_err <= 1, go to RESP.
  - A completion edge in the same cycle as the limit wins, giving a normal result with rsp_err=0.
- When undefined: no counter logic; WAIT waits indefinitely; rsp_err is tied 0.

Test Plan:
- Request (35,21) with rsp_ready=1 -> one core_go pulse with core_a=35, core_b=21; then rsp_valid with rsp_gcd=7, rsp_err=0; job_count=1.
- Back-to-back (56,98) then (12,18) -> rsp_gcd=14 then 6; exactly one core_go per job; job_count=2.
  - Core stub holds done high between jobs.
  - Check no early response from the stale done.
- Request (0,45), then (0,0) -> rsp_gcd=45, then 0; core_go never asserted; rsp_valid in the cycle after acceptance.
- Backpressure: (35,21) with rsp_ready low for 5 cycles after rsp_valid -> rsp_gcd=7 held stable, req_ready=0, job_count unchanged until the handshake.
- GCD_TIMEOUT_EN, TIMEOUT_CYCLES=255, core stub never asserts done -> rsp_valid=1, rsp_err=1, rsp_gcd=0, 255 cycles after WAIT entry.
- rst pulsed for one cycle mid-WAIT during (56,98) -> next cycle state IDLE, rsp_valid=0, job_count=0, req_ready=1; a new (35,21) job then returns 7.

Source files
------------

// File: rtl/gcd_job_sequencer.sv
// Request/response sequencer that launches GCD jobs on the top_gcd go/done core.
// Optional WAIT-state watchdog enabled by defining GCD_TIMEOUT_EN.
module gcd_job_sequencer #(
  parameter int unsigned WIDTH          = 7,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             core_go,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic [WIDTH-1:0] core_out,
  input  logic             core_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e           state_q;
  logic             core_go_q;
  logic [WIDTH-1:0] core_a_q;
  logic [WIDTH-1:0] core_b_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_gcd_q;
  logic [CNT_W-1:0] job_count_q;
  logic             done_q;
  logic             done_edge;

  // Only a rising done counts, so a level left over from the previous job is ignored.
  assign done_edge = core_done && !done_q;

`ifdef GCD_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             rsp_err_q;
  logic             tmo_hit;

  // Fires in the WAIT cycle whose increment would bring the count to the limit.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      core_go_q   <= 1'b0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_gcd_q   <= '0;
      job_count_q <= '0;
      done_q      <= 1'b0;
`ifdef GCD_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      done_q    <= core_done;
      core_go_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            core_a_q <= req_a;
            core_b_q <= req_b;
            // A zero operand makes the answer trivial; the core is never started.
            if ((req_a == '0) || (req_b == '0)) begin
              rsp_gcd_q   <= req_a | req_b;
              rsp_valid_q <= 1'b1;
`ifdef GCD_TIMEOUT_EN
              rsp_err_q   <= 1'b0;
`endif
              state_q     <= S_RESP;
            end else begin
              core_go_q <= 1'b1;
              state_q   <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
`ifdef GCD_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done_edge) begin
            rsp_gcd_q   <= core_out;
            rsp_valid_q <= 1'b1;
`ifdef GCD_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= S_RESP;
          end
`ifdef GCD_TIMEOUT_EN
          else if (tmo_hit) begin
            rsp_gcd_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            job_count_q <= job_count_q + CNT_W'(1);
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign core_go   = core_go_q;
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_gcd   = rsp_gcd_q;
  assign job_count = job_count_q;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural GCD core stub.
// Timeout checks run only when GCD_TIMEOUT_EN is defined.
module tb_gcd_job_sequencer;

  localparam int unsigned WIDTH    = 7;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned STUB_LAT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             core_go;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_out = '0;
  logic             core_done = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_gcd;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] job_count;

  int n_chk  = 0;
  int n_pass = 0;

  gcd_job_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .core_go   (core_go),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_out  (core_out),
    .core_done (core_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_gcd   (rsp_gcd),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .job_count (job_count)
  );

  always #5 clk = ~clk;

  // Core stub: done is held high until the next go; lazy mode drops it one cycle late.
  int unsigned      stub_cnt  = 0;
  logic [WIDTH-1:0] stub_res  = '0;
  bit               stub_lazy = 1'b0;
  bit               stub_mute = 1'b0;
  int               go_cnt    = 0;

  function automatic logic [WIDTH-1:0] euclid(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y, t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  always @(posedge clk) begin
    if (core_go) begin
      go_cnt   = go_cnt + 1;
      stub_res <= euclid(core_a, core_b);
      stub_cnt <= STUB_LAT;
      core_out <= '1;
      if (!stub_lazy) core_done <= 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == STUB_LAT) core_done <= 1'b0;
      if (stub_cnt == 1 && !stub_mute) begin
        core_done <= 1'b1;
        core_out  <= stub_res;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one request; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int t;
    t = 0;
    while (!req_ready && t < 50) begin
      tick();
      t++;
    end
    if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 400) begin
      tick();
      cyc++;
    end
    check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int saw;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_core_go",   32'(core_go),   32'd0);
    check("rst_job_count", 32'(job_count), 32'd0);
    check("rst_rsp_gcd",   32'(rsp_gcd),   32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_core_a",    32'(core_a),    32'd0);
    rst = 1'b0;
    tick();

    // Single job (35,21)
    send(7'd35, 7'd21);
    check("t1_go",        32'(core_go),   32'd1);
    check("t1_core_a",    32'(core_a),    32'd35);
    check("t1_core_b",    32'(core_b),    32'd21);
    check("t1_busy",      32'(busy),      32'd1);
    check("t1_req_ready", 32'(req_ready), 32'd0);
    tick();
    check("t1_go_pulse",  32'(core_go),   32'd0);
    wait_rsp("t1", cyc);
    check("t1_latency",   32'(cyc),       32'd5);
    check("t1_gcd",       32'(rsp_gcd),   32'd7);
    check("t1_err",       32'(rsp_err),   32'd0);
    tick();
    check("t1_valid_drop", 32'(rsp_valid), 32'd0);
    check("t1_job_count",  32'(job_count), 32'd1);
    check("t1_go_cnt",     32'(go_cnt),    32'd1);

    // Back-to-back with done held high between jobs and dropped late
    stub_lazy = 1'b1;
    send(7'd56, 7'd98);
    check("t2a_go", 32'(core_go), 32'd1);
    tick();
    check("t2a_stale_done", 32'(rsp_valid), 32'd0);
    wait_rsp("t2a", cyc);
    check("t2a_latency", 32'(cyc),     32'd5);
    check("t2a_gcd",     32'(rsp_gcd), 32'd14);
    tick();
    send(7'd12, 7'd18);
    tick();
    check("t2b_stale_done", 32'(rsp_valid), 32'd0);
    wait_rsp("t2b", cyc);
    check("t2b_gcd",       32'(rsp_gcd),   32'd6);
    tick();
    check("t2_job_count",  32'(job_count), 32'd3);
    check("t2_go_cnt",     32'(go_cnt),    32'd3);

    // Zero operands bypass the core
    send(7'd0, 7'd45);
    check("t3a_valid",   32'(rsp_valid), 32'd1);
    check("t3a_gcd",     32'(rsp_gcd),   32'd45);
    check("t3a_go",      32'(core_go),   32'd0);
    check("t3a_err",     32'(rsp_err),   32'd0);
    tick();
    send(7'd0, 7'd0);
    check("t3b_valid",   32'(rsp_valid), 32'd1);
    check("t3b_gcd",     32'(rsp_gcd),   32'd0);
    tick();
    check("t3_job_count", 32'(job_count), 32'd5);
    check("t3_go_cnt",    32'(go_cnt),    32'd3);

    // Response backpressure
    rsp_ready = 1'b0;
    send(7'd35, 7'd21);
    tick();
    wait_rsp("t4", cyc);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_gcd",   32'(rsp_gcd),   32'd7);
      check("t4_req_ready",  32'(req_ready), 32'd0);
      check("t4_job_count",  32'(job_count), 32'd5);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("t4_valid_drop", 32'(rsp_valid), 32'd0);
    check("t4_job_count_inc", 32'(job_count), 32'd6);

    // Reset in the middle of WAIT aborts the job
    send(7'd56, 7'd98);
    tick();
    tick();
    check("t5_in_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_req_ready", 32'(req_ready), 32'd1);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_job_count", 32'(job_count), 32'd0);
    check("t5_busy",      32'(busy),      32'd0);
    check("t5_core_go",   32'(core_go),   32'd0);
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) saw = 1;
    end
    check("t5_no_orphan_rsp", 32'(saw), 32'd0);
    send(7'd35, 7'd21);
    tick();
    wait_rsp("t5", cyc);
    check("t5_gcd", 32'(rsp_gcd), 32'd7);
    tick();
    check("t5_job_count_after", 32'(job_count), 32'd1);

`ifdef GCD_TIMEOUT_EN
    // Core never finishes: watchdog returns an error response
    stub_mute = 1'b1;
    send(7'd9, 7'd6);
    cyc = 0;
    while (!rsp_valid && cyc < 400) begin
      tick();
      cyc++;
    end
    check("t6_rsp_seen", 32'(rsp_valid), 32'd1);
    check("t6_latency",  32'(cyc),       32'd256);
    check("t6_err",      32'(rsp_err),   32'd1);
    check("t6_gcd",      32'(rsp_gcd),   32'd0);
    tick();
    check("t6_job_count", 32'(job_count), 32'd2);
    stub_mute = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
